// File: rtl/xconf_loader.sv
// Configuration loader: streams words from a source memory into the control
// port, optionally bracketed by an xconf clear and an xconf save, or issues a restore.
module xconf_loader #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned CTR_ADDR_W      = 6,
  parameter int unsigned MEM_ADDR_W      = 10,
  parameter int unsigned LEN_W           = 8,
  parameter int unsigned CONF_LIMIT      = 32,
  parameter int unsigned CONF_CLEAR_ADDR = 32,
  parameter int unsigned CONF_MEM_ADDR   = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  restore,
  input  logic                  abort,
  input  logic [MEM_ADDR_W-1:0] src_addr,
  input  logic [CTR_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]      len,
  input  logic                  clear_first,
  input  logic                  save_after,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  ctr_valid,
  output logic                  ctr_we,
  output logic [CTR_ADDR_W-1:0] ctr_addr,
  output logic [DATA_W-1:0]     ctr_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  localparam int unsigned IDX_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_STREAM  = 3'd3,
    S_SAVE    = 3'd4,
    S_RESTORE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Handshake: start/restore are single-cycle requests sampled only in IDLE;
  // mem_data must be valid the cycle after mem_en; every ctr_valid cycle is one
  // control access that the target accepts unconditionally.

  state_t                state_q;
  logic [MEM_ADDR_W-1:0] src_q;
  logic [CTR_ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]      len_q;
  logic                  clear_q;
  logic                  save_q;
  logic [LEN_W-1:0]      wr_idx_q;

  logic [31:0]           span_d;
  logic                  start_ok_d;
  logic [CTR_ADDR_W-1:0] wr_addr_d;
  logic [IDX_W-1:0]      rd_idx_d;
  logic                  rd_more_d;
  logic [MEM_ADDR_W-1:0] rd_addr_d;
  logic                  stream_end_d;

  // Reads run two words ahead of writes because mem_data is registered into ctr_data_out.
  always_comb begin
    span_d       = 32'(dst_addr) + 32'(len);
    start_ok_d   = (len != '0) && (span_d <= 32'(CONF_LIMIT));
    wr_addr_d    = dst_q + CTR_ADDR_W'(wr_idx_q);
    rd_idx_d     = {1'b0, wr_idx_q} + IDX_W'(2);
    rd_more_d    = rd_idx_d < {1'b0, len_q};
    rd_addr_d    = src_q + MEM_ADDR_W'(rd_idx_d);
    stream_end_d = (wr_idx_q == len_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      clear_q      <= 1'b0;
      save_q       <= 1'b0;
      wr_idx_q     <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      ctr_valid    <= 1'b0;
      ctr_we       <= 1'b0;
      ctr_addr     <= '0;
      ctr_data_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q   <= S_IDLE;
        mem_en    <= 1'b0;
        ctr_valid <= 1'b0;
        ctr_we    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              src_q    <= src_addr;
              dst_q    <= dst_addr;
              len_q    <= len;
              clear_q  <= clear_first;
              save_q   <= save_after;
              wr_idx_q <= '0;
              if (!start_ok_d) begin
                err <= 1'b1;
              end else if (clear_first) begin
                state_q      <= S_CLEAR;
                busy         <= 1'b1;
                ctr_valid    <= 1'b1;
                ctr_we       <= 1'b1;
                ctr_addr     <= CTR_ADDR_W'(CONF_CLEAR_ADDR);
                ctr_data_out <= '0;
              end else begin
                state_q  <= S_FETCH;
                busy     <= 1'b1;
                mem_en   <= 1'b1;
                mem_addr <= src_addr;
              end
            end else if (restore) begin
              state_q   <= S_RESTORE;
              busy      <= 1'b1;
              ctr_valid <= 1'b1;
              ctr_we    <= 1'b0;
              ctr_addr  <= CTR_ADDR_W'(CONF_MEM_ADDR);
            end
          end
          S_CLEAR: begin
            state_q   <= S_FETCH;
            ctr_valid <= 1'b0;
            ctr_we    <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= src_q;
          end
          S_FETCH: begin
            state_q <= S_STREAM;
            mem_en  <= (len_q > LEN_W'(1));
            if (len_q > LEN_W'(1)) begin
              mem_addr <= src_q + MEM_ADDR_W'(1);
            end
          end
          S_STREAM: begin
            if (stream_end_d) begin
              mem_en <= 1'b0;
              if (save_q) begin
                state_q      <= S_SAVE;
                ctr_valid    <= 1'b1;
                ctr_we       <= 1'b1;
                ctr_addr     <= CTR_ADDR_W'(CONF_MEM_ADDR);
                ctr_data_out <= '0;
              end else begin
                state_q   <= S_DONE;
                ctr_valid <= 1'b0;
                ctr_we    <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              ctr_valid    <= 1'b1;
              ctr_we       <= 1'b1;
              ctr_addr     <= wr_addr_d;
              ctr_data_out <= mem_data;
              wr_idx_q     <= wr_idx_q + LEN_W'(1);
              mem_en       <= rd_more_d;
              if (rd_more_d) begin
                mem_addr <= rd_addr_d;
              end
            end
          end
          S_SAVE, S_RESTORE: begin
            state_q   <= S_DONE;
            ctr_valid <= 1'b0;
            ctr_we    <= 1'b0;
            done      <= 1'b1;
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_q   <= S_IDLE;
            mem_en    <= 1'b0;
            ctr_valid <= 1'b0;
            ctr_we    <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_xconf_loader.sv
// Bench for xconf_loader: builds a per-cycle expected trace for every operation
// from the transfer rules and compares all outputs each cycle.
module tb_xconf_loader;

  localparam int DATA_W = 32;
  localparam int CA_W   = 6;
  localparam int MA_W   = 10;
  localparam int LEN_W  = 8;
  localparam int LIMIT  = 32;
  localparam int CLR_A  = 32;
  localparam int MEM_A  = 33;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic              cv;
    logic              we;
    logic [CA_W-1:0]   ca;
    logic [DATA_W-1:0] cd;
    logic              me;
    logic [MA_W-1:0]   ma;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, restore = 1'b0, abort = 1'b0;
  logic [MA_W-1:0]   src_addr = '0;
  logic [CA_W-1:0]   dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              clear_first = 1'b0, save_after = 1'b0;
  logic              mem_en, ctr_valid, ctr_we, busy, done, err;
  logic [MA_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic [CA_W-1:0]   ctr_addr;
  logic [DATA_W-1:0] ctr_data_out;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:(1<<MA_W)-1];
  obs_t              exp_q[$];
  int                compared = 0;
  int                mismatched = 0;
  logic [CA_W-1:0]   m_ca = '0;
  logic [DATA_W-1:0] m_cd = '0;
  logic [MA_W-1:0]   m_ma = '0;

  xconf_loader #(
    .DATA_W(DATA_W), .CTR_ADDR_W(CA_W), .MEM_ADDR_W(MA_W), .LEN_W(LEN_W),
    .CONF_LIMIT(LIMIT), .CONF_CLEAR_ADDR(CLR_A), .CONF_MEM_ADDR(MEM_A)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .restore(restore), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .clear_first(clear_first), .save_after(save_after),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .ctr_valid(ctr_valid), .ctr_we(ctr_we), .ctr_addr(ctr_addr),
    .ctr_data_out(ctr_data_out), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous source memory: one cycle read latency.
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  function automatic obs_t sample();
    return {busy, done, err, ctr_valid, ctr_we, ctr_addr, ctr_data_out, mem_en, mem_addr};
  endfunction

  task automatic check(input string tag, input int c, input obs_t e);
    obs_t got;
    got = sample();
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s cyc%0d: observed %h expected %h", tag, c, got, e);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0;
    e.ca = m_ca; e.cd = m_cd; e.ma = m_ma;
    return e;
  endfunction

  // kind 0: start, 1: restore only, 2: start and restore together.
  task automatic run_op(input string tag, input int kind, input logic [MA_W-1:0] src,
                        input logic [CA_W-1:0] dst, input int ln, input bit clr,
                        input bit sav, input int abort_at_in);
    int   ok, off, done_c, n, abort_at, k;
    obs_t e;
    abort_at = abort_at_in;
    ok = (kind == 1) || (ln != 0 && int'(dst) + ln <= LIMIT);
    off = clr ? 1 : 0;
    done_c = (kind == 1) ? 1 : off + 2 + ln + (sav ? 1 : 0);
    if (!ok) abort_at = -1;
    else if (abort_at == -2) abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, done_c - 1)) : -1;
    n = ok ? done_c + 3 : 3;
    for (int c = 0; c < n; c++) begin
      e = idle_obs();
      if (!ok) begin
        e.err = (c == 0);
      end else if (abort_at >= 0 && c > abort_at) begin
        e = idle_obs();
      end else if (kind == 1) begin
        e.busy = (c <= 1);
        if (c == 0) begin e.cv = 1; e.we = 0; e.ca = CA_W'(MEM_A); end
        e.done = (c == 1);
      end else begin
        e.busy = (c <= done_c);
        if (clr && c == 0) begin e.cv = 1; e.we = 1; e.ca = CA_W'(CLR_A); e.cd = '0; end
        if (c >= off && c < off + ln) begin e.me = 1; e.ma = src + MA_W'(c - off); end
        if (c >= off + 2 && c < off + 2 + ln) begin
          k = c - off - 2;
          e.cv = 1; e.we = 1; e.ca = dst + CA_W'(k); e.cd = mem[src + MA_W'(k)];
        end
        if (sav && c == off + 2 + ln) begin e.cv = 1; e.we = 1; e.ca = CA_W'(MEM_A); e.cd = '0; end
        e.done = (c == done_c);
      end
      m_ca = e.ca; m_cd = e.cd; m_ma = e.ma;
      exp_q.push_back(e);
    end
    start = (kind != 1); restore = (kind != 0);
    src_addr = src; dst_addr = dst; len = LEN_W'(ln); clear_first = clr; save_after = sav;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start = 0; restore = 0; abort = 0;
      e = exp_q.pop_front();
      check(tag, c, e);
      if (c == abort_at) abort = 1;
      else if (e.busy && $urandom_range(0, 2) == 0) begin
        start = 1; restore = $urandom_range(0, 1);
        src_addr = MA_W'($urandom); dst_addr = CA_W'($urandom_range(0, 8));
        len = LEN_W'($urandom_range(1, 4)); clear_first = $urandom_range(0, 1);
        save_after = $urandom_range(0, 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << MA_W); i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = DATA_W'(32'hA0 + i);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("reset", 0, '0);
    assert (dbg_state === 3'd0) else begin
      mismatched++; $error("FAIL reset_state: observed %0d expected 0", dbg_state);
    end
    compared++;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 0, idle_obs());

    run_op("load4",        0, 10'd0,    6'd0,  4, 0, 0, -1);
    run_op("clr_save2",    0, 10'd50,   6'd5,  2, 1, 1, -1);
    run_op("err_30_3",     0, 10'd7,    6'd30, 3, 0, 0, -1);
    run_op("ok_29_3",      0, 10'd7,    6'd29, 3, 0, 0, -1);
    run_op("err_len0",     0, 10'd7,    6'd3,  0, 0, 0, -1);
    run_op("full_32",      0, 10'd100,  6'd0,  32, 1, 0, -1);
    run_op("restore",      1, 10'd0,    6'd0,  0, 0, 0, -1);
    run_op("start_wins",   2, 10'd200,  6'd8,  2, 0, 1, -1);
    run_op("abort_stream", 0, 10'd300,  6'd4,  8, 0, 0, 2);
    run_op("after_abort",  0, 10'd310,  6'd10, 3, 0, 0, -1);
    run_op("src_wrap",     0, 10'd1022, 6'd1,  5, 0, 1, -1);
    run_op("len1",         0, 10'd555,  6'd31, 1, 1, 1, -1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0)
        run_op("rand_restore", 1, '0, '0, 0, 0, 0, -2);
      else
        run_op("rand_load", 0, MA_W'($urandom), CA_W'($urandom_range(0, 36)),
               int'($urandom_range(0, 10)), $urandom_range(0, 1), $urandom_range(0, 1), -2);
    end

    // Reset asserted in the middle of a stream.
    start = 1; src_addr = 10'd400; dst_addr = 6'd2; len = 8'd8; clear_first = 0; save_after = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_async", 0, '0);
    @(posedge clk); #1;
    check("rst_held", 1, '0);
    rst = 1'b1;
    m_ca = '0; m_cd = '0; m_ma = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_quiet", c, idle_obs());
    end
    run_op("after_rst", 0, 10'd20, 6'd12, 4, 1, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
